instruction_fetch_stage: RTL and testbench

- Front pipeline stage. Owns the program counter and fetches 64-bit instruction words from a 1-cycle-latency synchronous instruction memory.
- Delivers instructions with their PC to the datapath controller (decode) over a valid/ready handshake.
- Applies branch redirects signalled by the controller's PCChangeEnable.
- A 2-entry fetch buffer absorbs decode back-pressure, so no fetched word is lost or duplicated.

---
 rtl/pipeline_pkg.sv | 37 +++
 rtl/fetch_buffer.sv | 83 ++++++++
 rtl/instruction_fetch_stage.sv | 113 +++++++++++
 tb/tb_instruction_fetch_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the instruction pipeline front end.
package pipeline_pkg;

  localparam int DEFAULT_INSTR_W = 64;
  localparam int DEFAULT_ADDR_W  = 8;

  // Instruction field slices (hi/lo bit positions)
  localparam int MEM_OP_HI      = 63;
  localparam int MEM_OP_LO      = 62;
  localparam int SRC_SEL_HI     = 61;
  localparam int SRC_SEL_LO     = 60;
  localparam int ALU_OP_HI      = 59;
  localparam int ALU_OP_LO      = 58;
  localparam int BRANCH_COND_HI = 57;
  localparam int BRANCH_COND_LO = 56;
  localparam int TARGET_HI      = 55;
  localparam int TARGET_LO      = 48;
  localparam int SRC_A_HI       = 47;
  localparam int SRC_A_LO       = 40;
  localparam int SRC_B_HI       = 39;
  localparam int SRC_B_LO       = 32;
  localparam int IMM_HI         = 31;
  localparam int IMM_LO         = 0;

  // Fetch control states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  // Branch target field of an instruction word
  function automatic logic [DEFAULT_ADDR_W-1:0] target_of(input logic [DEFAULT_INSTR_W-1:0] instr);
    return instr[TARGET_HI:TARGET_LO];
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instruction}; the head entry drives the outputs directly.
module fetch_buffer import pipeline_pkg::*; #(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int INSTR_W = DEFAULT_INSTR_W
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               flush,
  input  logic               push,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic               full,
  output logic               empty
);

  localparam int DEPTH = 2;

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         count_reg;
  logic [DEPTH-1:0]   wr_en;
  logic               do_push;
  logic               do_pop;

  // A flush cancels any same-cycle push or pop
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = do_push && (wr_ptr_reg == 1'(gi));
    end
  endgenerate

  // Entry storage; cleared on reset so the outputs read zero
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          pc_mem[i]    <= push_pc;
          instr_mem[i] <= push_instr;
        end
      end
    end
  end

  // Pointers and occupancy; push+pop when full writes the slot being vacated
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_pc    = pc_mem[rd_ptr_reg];
  assign head_instr = instr_mem[rd_ptr_reg];
  assign full       = (count_reg == 2'd2);
  assign empty      = (count_reg == 2'd0);

  push_into_full_a: assert property (@(posedge clk) disable iff (!resetN)
    !(do_push && full && !do_pop));

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, reads a 1-cycle synchronous instruction memory,
// and hands {instruction, pc} to decode through a 2-entry buffer.
module instruction_fetch_stage import pipeline_pkg::*; #(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                INSTR_W  = DEFAULT_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               fetchEnable,
  output logic [ADDR_W-1:0]  imemAddr,
  output logic               imemReq,
  input  logic [INSTR_W-1:0] imemData,
  input  logic               branchTaken,
  input  logic [ADDR_W-1:0]  branchTarget,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instrPC,
  output logic               instrValid,
  input  logic               instrReady
);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] inflight_addr_reg;
  logic              epoch_reg;
  logic              inflight_reg;
  logic              inflight_epoch_reg;
  logic              req;
  logic              push;
  logic              pop;
  logic              buf_full;
  logic              buf_empty;
  logic [2:0]        occupancy;

  // A redirect flushes the head instead of transferring it
  assign pop  = instrValid && instrReady && !branchTaken;
  // Only responses from the current path are kept
  assign push = inflight_reg && (inflight_epoch_reg == epoch_reg) && !branchTaken;

  // Slots committed after this cycle: entries left after the pop plus the
  // response landing now. Counting the pop keeps back-to-back fetch at 1/cycle.
  assign occupancy = {1'b0, buf_full, !buf_full && !buf_empty}
                   - {2'b00, pop} + {2'b00, inflight_reg};

  // Next-state and request decode; a redirect always wins
  always_comb begin
    state_next = state_reg;
    req        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (fetchEnable) state_next = RUN;
      end
      RUN: begin
        req = (occupancy < 3'd2) && !branchTaken;
        if (!fetchEnable) state_next = IDLE;
      end
      REDIRECT: begin
        state_next = fetchEnable ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (branchTaken) state_next = REDIRECT;
  end

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // PC, epoch and in-flight request tracking
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pc_reg             <= RESET_PC;
      epoch_reg          <= 1'b0;
      inflight_reg       <= 1'b0;
      inflight_epoch_reg <= 1'b0;
      inflight_addr_reg  <= RESET_PC;
    end else begin
      inflight_reg       <= req;
      inflight_epoch_reg <= epoch_reg;
      inflight_addr_reg  <= pc_reg;
      if (branchTaken) begin
        pc_reg    <= branchTarget;
        epoch_reg <= ~epoch_reg;
      end else if (req) begin
        pc_reg <= pc_reg + ADDR_W'(1);
      end
    end
  end

  assign imemReq  = req;
  assign imemAddr = pc_reg;
  assign instrValid = !buf_empty;

  fetch_buffer #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_fetch_buffer (
    .clk        (clk),
    .resetN     (resetN),
    .flush      (branchTaken),
    .push       (push),
    .push_pc    (inflight_addr_reg),
    .push_instr (imemData),
    .pop        (pop),
    .head_pc    (instrPC),
    .head_instr (instruction),
    .full       (buf_full),
    .empty      (buf_empty)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus a random phase.
// Expected delivery path is a queue of consecutive addresses from the last
// redirect/reset point; a negedge monitor pops and compares every transfer.
module tb_instruction_fetch_stage;

  localparam int             AW     = 8;
  localparam int             IW     = 64;
  localparam logic [AW-1:0]  RST_PC = '0;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetN;
  logic          fetchEnable;
  logic          branchTaken;
  logic [AW-1:0] branchTarget;
  logic          instrReady;
  logic [AW-1:0] imemAddr;
  logic          imemReq;
  logic [IW-1:0] imemData = '0;
  logic [IW-1:0] instruction;
  logic [AW-1:0] instrPC;
  logic          instrValid;

  logic [IW-1:0] mem [256];
  exp_t          exp_q [$];
  logic [AW-1:0] req_log [$];
  exp_t          mon_e;
  int            errors = 0;
  int            checks = 0;
  int            delivered = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk          (clk),
    .resetN       (resetN),
    .fetchEnable  (fetchEnable),
    .imemAddr     (imemAddr),
    .imemReq      (imemReq),
    .imemData     (imemData),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .instruction  (instruction),
    .instrPC      (instrPC),
    .instrValid   (instrValid),
    .instrReady   (instrReady)
  );

  // Synchronous instruction memory, one cycle read latency
  always @(posedge clk) begin
    if (imemReq) imemData <= mem[imemAddr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected path: consecutive (wrapping) addresses starting at start
  function automatic void refill(input logic [AW-1:0] start);
    exp_q.delete();
    for (int k = 0; k < 256; k++) begin
      logic [AW-1:0] a;
      a = start + AW'(k);
      exp_q.push_back('{pc: a, data: mem[a]});
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer happens at the next edge when valid && ready && no redirect
  always @(negedge clk) begin
    if (resetN && instrValid && instrReady && !branchTaken) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deliver_unexpected: got pc %h expected no transfer", instrPC);
      end else begin
        mon_e = exp_q.pop_front();
        check("deliver_pc", 64'(instrPC), 64'(mon_e.pc));
        check("deliver_instr", instruction, mon_e.data);
        delivered++;
        $display("deliver pc=%h instr=%h", instrPC, instruction);
      end
    end
    if (resetN && imemReq) req_log.push_back(imemAddr);
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rnd_start;
    int since;
    logic [AW-1:0] ea;

    resetN       = 1'b0;
    fetchEnable  = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = '0;
    instrReady   = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 64'(i) * 64'h11;
    refill(RST_PC);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req",   64'(imemReq),    64'd0);
    check("rst_addr",  64'(imemAddr),   64'(RST_PC));
    check("rst_valid", 64'(instrValid), 64'd0);
    check("rst_instr", instruction,     64'd0);
    check("rst_pc",    64'(instrPC),    64'd0);
    #2 resetN = 1'b1;
    repeat (2) step();

    // Start-up latency and streaming
    fetchEnable = 1'b1;
    step();
    @(negedge clk);
    check("lat_req0",   64'(imemReq),    64'd1);
    check("lat_addr0",  64'(imemAddr),   64'd0);
    check("lat_valid0", 64'(instrValid), 64'd0);
    step();
    @(negedge clk);
    check("lat_req1",   64'(imemReq),    64'd1);
    check("lat_addr1",  64'(imemAddr),   64'd1);
    check("lat_valid1", 64'(instrValid), 64'd0);
    step();
    @(negedge clk);
    check("lat_valid2", 64'(instrValid), 64'd1);
    check("lat_pc2",    64'(instrPC),    64'd0);
    check("lat_addr2",  64'(imemAddr),   64'd2);
    repeat (8) step();

    // Back-pressure: output holds the expected head, no requests
    instrReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      @(negedge clk);
      check("bp_req",   64'(imemReq),    64'd0);
      check("bp_valid", 64'(instrValid), 64'd1);
      check("bp_pc",    64'(instrPC),    64'(exp_q[0].pc));
      check("bp_instr", instruction,     exp_q[0].data);
    end
    step();
    instrReady = 1'b1;
    repeat (6) step();

    // Redirect with a full buffer and a same-cycle ready
    instrReady = 1'b0;
    step();
    step();
    branchTaken  = 1'b1;
    branchTarget = 8'h40;
    instrReady   = 1'b1;
    refill(8'h40);
    @(negedge clk);
    check("redir_req", 64'(imemReq), 64'd0);
    step();
    branchTaken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("redir_gap", 64'(instrValid), 64'd0);
      step();
    end
    @(negedge clk);
    check("redir_valid", 64'(instrValid), 64'd1);
    check("redir_pc",    64'(instrPC),    64'h40);
    repeat (6) step();

    // PC wrap
    branchTaken  = 1'b1;
    branchTarget = 8'hFE;
    refill(8'hFE);
    req_log.delete();
    step();
    branchTaken = 1'b0;
    repeat (8) step();
    for (int k = 0; k < 4; k++) begin
      ea = 8'hFE + AW'(k);
      check("wrap_addr", (k < req_log.size()) ? 64'(req_log[k]) : 64'hDEAD, 64'(ea));
    end

    // Asynchronous reset mid-stream with a request in flight
    @(posedge clk);
    #3 resetN = 1'b0;
    #1;
    check("mrst_valid", 64'(instrValid), 64'd0);
    check("mrst_instr", instruction,     64'd0);
    check("mrst_pc",    64'(instrPC),    64'd0);
    check("mrst_req",   64'(imemReq),    64'd0);
    check("mrst_addr",  64'(imemAddr),   64'(RST_PC));
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    refill(RST_PC);
    req_log.delete();
    #2 resetN = 1'b1;
    repeat (6) step();
    check("mrst_first_req",  (req_log.size() > 0) ? 64'(req_log[0]) : 64'hDEAD, 64'(RST_PC));
    check("mrst_second_req", (req_log.size() > 1) ? 64'(req_log[1]) : 64'hDEAD, 64'(RST_PC + 8'd1));

    // Back-to-back redirects: latest target wins
    branchTaken  = 1'b1;
    branchTarget = 8'h10;
    refill(8'h10);
    req_log.delete();
    step();
    branchTarget = 8'h20;
    refill(8'h20);
    step();
    branchTaken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("b2b_gap", 64'(instrValid), 64'd0);
      step();
    end
    @(negedge clk);
    check("b2b_valid", 64'(instrValid), 64'd1);
    check("b2b_pc",    64'(instrPC),    64'h20);
    repeat (4) step();
    check("b2b_first_req", (req_log.size() > 0) ? 64'(req_log[0]) : 64'hDEAD, 64'h20);

    // Random phase
    rnd_start = delivered;
    since = 0;
    repeat (800) begin
      step();
      instrReady  = ($urandom_range(0, 3) != 0);
      fetchEnable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 24) == 0 || since > 200) begin
        branchTaken  = 1'b1;
        branchTarget = AW'($urandom_range(0, 255));
        refill(branchTarget);
        since = 0;
      end else begin
        branchTaken = 1'b0;
        since++;
      end
    end
    step();
    branchTaken = 1'b0;
    fetchEnable = 1'b1;
    instrReady  = 1'b1;
    repeat (10) step();
    check("rnd_progress", 64'((delivered - rnd_start) >= 100), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
